// File: rtl/image_ctrl_pkg.sv
// Shared constants and FSM state types for the ImageController AXI4 slave front-end.
// Offsets are 16-byte word indices, i.e. address bits [11:4].
package image_ctrl_pkg;

   localparam logic [7:0] OFS_WRITE_FIFO   = 8'h00;
   localparam logic [7:0] OFS_FLUSH        = 8'h01;
   localparam logic [7:0] OFS_SIZE         = 8'h02;
   localparam logic [7:0] OFS_DONE         = 8'h03;
   localparam logic [7:0] OFS_BUFFER       = 8'h04;
   localparam logic [7:0] OFS_NEW_IMAGE    = 8'h05;
   localparam logic [7:0] OFS_DEASSERT_IRQ = 8'h06;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_e;
   typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;

   function automatic logic ofs_known(input logic [7:0] ofs);
      return ofs <= OFS_DEASSERT_IRQ;
   endfunction

endpackage

// File: rtl/image_ctrl_axi_rd.sv
// Read channel of the ImageController AXI4 slave: single-beat status reads.
//   state   | meaning
//   RD_IDLE | waiting for arvalid; arready is high for the accepting cycle
//   RD_DATA | rdata/rresp held with rvalid and rlast until rready
module image_ctrl_axi_rd
   import image_ctrl_pkg::*;
#(
   parameter logic [38:0] BASE_ADDR = 39'h00_A001_0000,
   parameter int          ID_W      = 17,
   parameter int          DATA_W    = 128
) (
   input  logic              s_axi_aclk,
   input  logic              s_axi_areset,
   input  logic [38:0]       araddr,
   input  logic [ID_W-1:0]   arid,
   input  logic              arvalid,
   output logic              arready,
   output logic [DATA_W-1:0] rdata,
   output logic [ID_W-1:0]   rid,
   output logic [1:0]        rresp,
   output logic              rlast,
   output logic              rvalid,
   input  logic              rready,
   input  logic [31:0]       image_width,
   input  logic [31:0]       image_height,
   input  logic              irq_signal
);

   rd_state_e         rd_state_q, rd_state_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [ID_W-1:0]   rid_q, rid_d;
   logic [1:0]        rresp_q, rresp_d;
   logic              rvalid_q, rvalid_d;
   logic              base_ok;
   logic              unused_rd;

   assign unused_rd = ^araddr[3:0];
   assign base_ok   = (araddr[38:12] == BASE_ADDR[38:12]);
   assign arready   = !s_axi_areset && (rd_state_q == RD_IDLE) && arvalid;

   always_comb begin
      rd_state_d = rd_state_q;
      rdata_d    = rdata_q;
      rid_d      = rid_q;
      rresp_d    = rresp_q;
      rvalid_d   = rvalid_q;
      case (rd_state_q)
         RD_IDLE: begin
            if (arready) begin
               rd_state_d = RD_DATA;
               rvalid_d   = 1'b1;
               rid_d      = arid;
               rdata_d    = '0;
               rresp_d    = RESP_OKAY;
               if (!base_ok) begin
                  rresp_d = RESP_SLVERR;
               end else begin
                  case (araddr[11:4])
                     OFS_SIZE:         rdata_d = {{(DATA_W-64){1'b0}}, image_height, image_width};
                     OFS_DEASSERT_IRQ: rdata_d = {{(DATA_W-1){1'b0}}, irq_signal};
                     default:          rresp_d = RESP_SLVERR;
                  endcase
               end
            end
         end
         RD_DATA: begin
            if (rready) begin
               rvalid_d   = 1'b0;
               rd_state_d = RD_IDLE;
            end
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         rd_state_q <= RD_IDLE;
         rdata_q    <= '0;
         rid_q      <= '0;
         rresp_q    <= RESP_OKAY;
         rvalid_q   <= 1'b0;
      end else begin
         rd_state_q <= rd_state_d;
         rdata_q    <= rdata_d;
         rid_q      <= rid_d;
         rresp_q    <= rresp_d;
         rvalid_q   <= rvalid_d;
      end
   end

   assign rdata  = rdata_q;
   assign rid    = rid_q;
   assign rresp  = rresp_q;
   assign rvalid = rvalid_q;
   assign rlast  = rvalid_q;

endmodule

// File: rtl/image_ctrl_axi_slave.sv
// AXI4 slave front-end of the ImageController: decodes single-beat writes into
// FIFO/buffer strobes and command pulses, owns image size and the new-image IRQ.
//   state   | meaning
//   WR_IDLE | waiting for awvalid; awready high for the accepting cycle
//   WR_DATA | address latched; wready unless the target FIFO/buffer is full
//   WR_RESP | bvalid held with latched id until bready
module image_ctrl_axi_slave
   import image_ctrl_pkg::*;
#(
   parameter logic [38:0] BASE_ADDR = 39'h00_A001_0000,
   parameter int          ID_W      = 17,
   parameter int          DATA_W    = 128
) (
   input  logic                s_axi_aclk,
   input  logic                s_axi_areset,
   input  logic [38:0]         awaddr,
   input  logic [ID_W-1:0]     awid,
   input  logic [7:0]          awlen,
   input  logic [2:0]          awsize,
   input  logic                awvalid,
   output logic                awready,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic                wlast,
   input  logic                wvalid,
   output logic                wready,
   output logic [ID_W-1:0]     bid,
   output logic [1:0]          bresp,
   output logic                bvalid,
   input  logic                bready,
   input  logic [38:0]         araddr,
   input  logic [ID_W-1:0]     arid,
   input  logic                arvalid,
   output logic                arready,
   output logic [DATA_W-1:0]   rdata,
   output logic [ID_W-1:0]     rid,
   output logic [1:0]          rresp,
   output logic                rlast,
   output logic                rvalid,
   input  logic                rready,
   output logic                fifo_wr_en,
   output logic [DATA_W-1:0]   fifo_din,
   input  logic                fifo_full,
   output logic                flush_fifo,
   output logic [31:0]         image_width,
   output logic [31:0]         image_height,
   output logic                data_done,
   output logic                buf_wr_en,
   output logic [DATA_W-1:0]   buf_din,
   input  logic                buf_full,
   input  logic                image_change,
   output logic                irq_signal
);

   wr_state_e         wr_state_q, wr_state_d;
   logic [7:0]        ofs_q, ofs_d;
   logic [ID_W-1:0]   awid_q, awid_d;
   logic              wr_err_q, wr_err_d;
   logic              burst_q, burst_d;
   logic              bvalid_q, bvalid_d;
   logic [1:0]        bresp_q, bresp_d;
   logic [ID_W-1:0]   bid_q, bid_d;
   logic              fifo_wr_en_q, fifo_wr_en_d;
   logic [DATA_W-1:0] fifo_din_q, fifo_din_d;
   logic              buf_wr_en_q, buf_wr_en_d;
   logic [DATA_W-1:0] buf_din_q, buf_din_d;
   logic              flush_q, flush_d;
   logic              done_q, done_d;
   logic [31:0]       width_q, width_d;
   logic [31:0]       height_q, height_d;
   logic              irq_q, irq_d;
   logic              wr_blocked, w_hs, wr_ok, irq_set, irq_clr;
   logic              unused_wr;

   assign unused_wr = ^{awsize, wstrb, awaddr[3:0]};

   // Back-pressure only applies to decodable single-beat writes to a full target.
   assign wr_blocked = !wr_err_q &&
                       (((ofs_q == OFS_WRITE_FIFO) && fifo_full) ||
                        ((ofs_q == OFS_BUFFER) && buf_full));
   assign awready = !s_axi_areset && (wr_state_q == WR_IDLE) && awvalid;
   assign wready  = !s_axi_areset && (wr_state_q == WR_DATA) && !wr_blocked;
   assign w_hs    = wready && wvalid;
   assign wr_ok   = w_hs && !wr_err_q;
   assign irq_set = image_change || (wr_ok && (ofs_q == OFS_NEW_IMAGE));
   assign irq_clr = wr_ok && (ofs_q == OFS_DEASSERT_IRQ);

   always_comb begin
      wr_state_d   = wr_state_q;
      ofs_d        = ofs_q;
      awid_d       = awid_q;
      wr_err_d     = wr_err_q;
      burst_d      = burst_q;
      bvalid_d     = bvalid_q;
      bresp_d      = bresp_q;
      bid_d        = bid_q;
      fifo_wr_en_d = 1'b0;
      fifo_din_d   = fifo_din_q;
      buf_wr_en_d  = 1'b0;
      buf_din_d    = buf_din_q;
      flush_d      = 1'b0;
      done_d       = 1'b0;
      width_d      = width_q;
      height_d     = height_q;
      irq_d        = irq_set ? 1'b1 : (irq_clr ? 1'b0 : irq_q);

      case (wr_state_q)
         WR_IDLE: begin
            if (awready) begin
               wr_state_d = WR_DATA;
               ofs_d      = awaddr[11:4];
               awid_d     = awid;
               burst_d    = (awlen != 8'd0);
               wr_err_d   = (awaddr[38:12] != BASE_ADDR[38:12]) ||
                            !ofs_known(awaddr[11:4]) || (awlen != 8'd0);
            end
         end
         WR_DATA: begin
            if (w_hs && (!burst_q || wlast)) begin
               wr_state_d = WR_RESP;
               bvalid_d   = 1'b1;
               bresp_d    = wr_err_q ? RESP_SLVERR : RESP_OKAY;
               bid_d      = awid_q;
            end
         end
         WR_RESP: begin
            if (bready) begin
               bvalid_d   = 1'b0;
               wr_state_d = WR_IDLE;
            end
         end
         default: wr_state_d = WR_IDLE;
      endcase

      if (wr_ok) begin
         case (ofs_q)
            OFS_WRITE_FIFO: begin
               fifo_wr_en_d = 1'b1;
               fifo_din_d   = wdata;
            end
            OFS_FLUSH: flush_d = 1'b1;
            OFS_SIZE: begin
               width_d  = wdata[31:0];
               height_d = wdata[63:32];
            end
            OFS_DONE: done_d = 1'b1;
            OFS_BUFFER: begin
               buf_wr_en_d = 1'b1;
               buf_din_d   = wdata;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         wr_state_q   <= WR_IDLE;
         ofs_q        <= '0;
         awid_q       <= '0;
         wr_err_q     <= 1'b0;
         burst_q      <= 1'b0;
         bvalid_q     <= 1'b0;
         bresp_q      <= RESP_OKAY;
         bid_q        <= '0;
         fifo_wr_en_q <= 1'b0;
         fifo_din_q   <= '0;
         buf_wr_en_q  <= 1'b0;
         buf_din_q    <= '0;
         flush_q      <= 1'b0;
         done_q       <= 1'b0;
         width_q      <= '0;
         height_q     <= '0;
         irq_q        <= 1'b0;
      end else begin
         wr_state_q   <= wr_state_d;
         ofs_q        <= ofs_d;
         awid_q       <= awid_d;
         wr_err_q     <= wr_err_d;
         burst_q      <= burst_d;
         bvalid_q     <= bvalid_d;
         bresp_q      <= bresp_d;
         bid_q        <= bid_d;
         fifo_wr_en_q <= fifo_wr_en_d;
         fifo_din_q   <= fifo_din_d;
         buf_wr_en_q  <= buf_wr_en_d;
         buf_din_q    <= buf_din_d;
         flush_q      <= flush_d;
         done_q       <= done_d;
         width_q      <= width_d;
         height_q     <= height_d;
         irq_q        <= irq_d;
      end
   end

   assign bvalid       = bvalid_q;
   assign bresp        = bresp_q;
   assign bid          = bid_q;
   assign fifo_wr_en   = fifo_wr_en_q;
   assign fifo_din     = fifo_din_q;
   assign buf_wr_en    = buf_wr_en_q;
   assign buf_din      = buf_din_q;
   assign flush_fifo   = flush_q;
   assign data_done    = done_q;
   assign image_width  = width_q;
   assign image_height = height_q;
   assign irq_signal   = irq_q;

   image_ctrl_axi_rd #(
      .BASE_ADDR (BASE_ADDR),
      .ID_W      (ID_W),
      .DATA_W    (DATA_W)
   ) u_rd (
      .s_axi_aclk   (s_axi_aclk),
      .s_axi_areset (s_axi_areset),
      .araddr       (araddr),
      .arid         (arid),
      .arvalid      (arvalid),
      .arready      (arready),
      .rdata        (rdata),
      .rid          (rid),
      .rresp        (rresp),
      .rlast        (rlast),
      .rvalid       (rvalid),
      .rready       (rready),
      .image_width  (width_q),
      .image_height (height_q),
      .irq_signal   (irq_q)
   );

endmodule

// File: tb/tb_image_ctrl_axi_slave.sv
// Directed bench for image_ctrl_axi_slave: register writes, buffer streaming with
// back-pressure, IRQ set/clear priority, error responses and reset mid-response.
module tb_image_ctrl_axi_slave;

   localparam logic [38:0] BASE = 39'h00_A001_0000;

   logic         s_axi_aclk = 1'b0;
   logic         s_axi_areset;
   logic [38:0]  awaddr;
   logic [16:0]  awid;
   logic [7:0]   awlen;
   logic [2:0]   awsize;
   logic         awvalid, awready;
   logic [127:0] wdata;
   logic [15:0]  wstrb;
   logic         wlast, wvalid, wready;
   logic [16:0]  bid;
   logic [1:0]   bresp;
   logic         bvalid, bready;
   logic [38:0]  araddr;
   logic [16:0]  arid;
   logic         arvalid, arready;
   logic [127:0] rdata;
   logic [16:0]  rid;
   logic [1:0]   rresp;
   logic         rlast, rvalid, rready;
   logic         fifo_wr_en;
   logic [127:0] fifo_din;
   logic         fifo_full, flush_fifo;
   logic [31:0]  image_width, image_height;
   logic         data_done, buf_wr_en;
   logic [127:0] buf_din;
   logic         buf_full, image_change, irq_signal;

   always #5 s_axi_aclk = ~s_axi_aclk;

   image_ctrl_axi_slave dut (
      .s_axi_aclk(s_axi_aclk), .s_axi_areset(s_axi_areset),
      .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arid(arid), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_full(fifo_full), .flush_fifo(flush_fifo),
      .image_width(image_width), .image_height(image_height), .data_done(data_done),
      .buf_wr_en(buf_wr_en), .buf_din(buf_din), .buf_full(buf_full),
      .image_change(image_change), .irq_signal(irq_signal)
   );

   int n_checks = 0;
   int n_err    = 0;
   int cnt_fifo = 0, cnt_buf = 0, cnt_flush = 0, cnt_done = 0, buf_exp = 0;
   logic [127:0] last_fifo_din = '0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Output monitor: buffer data must arrive strictly in order, pulses are counted per cycle.
   always @(negedge s_axi_aclk) begin
      if (buf_wr_en) begin
         chk("buf_din_order", buf_din, 128'(buf_exp));
         buf_exp++;
         cnt_buf++;
      end
      if (fifo_wr_en) begin
         cnt_fifo++;
         last_fifo_din = fifo_din;
      end
      if (flush_fifo) cnt_flush++;
      if (data_done)  cnt_done++;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [38:0] a(input logic [11:0] ofs);
      return BASE + 39'(ofs);
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge s_axi_aclk);
   endtask

   task automatic aw_phase(input logic [38:0] addr, input logic [16:0] id, input logic [7:0] len);
      bit seen = 1'b0;
      awaddr = addr; awid = id; awlen = len; awvalid = 1'b1;
      for (int i = 0; i < 100 && !seen; i++) begin
         #1 seen = awready;
         @(negedge s_axi_aclk);
      end
      awvalid = 1'b0;
      if (!seen) chk("aw_handshake_timeout", 128'(seen), 128'd1);
   endtask

   task automatic w_phase(input logic [127:0] data, input logic last);
      bit seen = 1'b0;
      wdata = data; wlast = last; wvalid = 1'b1;
      for (int i = 0; i < 100 && !seen; i++) begin
         #1 seen = wready;
         @(negedge s_axi_aclk);
      end
      wvalid = 1'b0; wlast = 1'b0;
      if (!seen) chk("w_handshake_timeout", 128'(seen), 128'd1);
   endtask

   task automatic b_phase(output logic [1:0] resp, output logic [16:0] id);
      bit seen = 1'b0;
      resp = 2'bxx; id = 'x;
      for (int i = 0; i < 100 && !seen; i++) begin
         #1 if (bvalid) begin
            seen = 1'b1; resp = bresp; id = bid;
         end
         @(negedge s_axi_aclk);
      end
      if (!seen) chk("b_handshake_timeout", 128'(seen), 128'd1);
   endtask

   task automatic wr(input logic [38:0] addr, input logic [16:0] id, input logic [127:0] data,
                     output logic [1:0] resp, output logic [16:0] rbid);
      aw_phase(addr, id, 8'd0);
      w_phase(data, 1'b1);
      b_phase(resp, rbid);
   endtask

   task automatic stall_wr(input logic [38:0] addr, input logic [127:0] data, input bit use_buf,
                           input int n, output int low_cycles, output logic [1:0] resp);
      logic [16:0] rbid;
      aw_phase(addr, 17'h7, 8'd0);
      if (use_buf) buf_full = 1'b1; else fifo_full = 1'b1;
      wdata = data; wlast = 1'b1; wvalid = 1'b1;
      low_cycles = 0;
      for (int i = 0; i < n; i++) begin
         #1 if (!wready) low_cycles++;
         @(negedge s_axi_aclk);
      end
      buf_full = 1'b0; fifo_full = 1'b0;
      w_phase(data, 1'b1);
      b_phase(resp, rbid);
   endtask

   task automatic rd(input logic [38:0] addr, input logic [16:0] id, output logic [127:0] data,
                     output logic [1:0] resp, output logic [16:0] rrid, output logic last);
      bit seen = 1'b0;
      araddr = addr; arid = id; arvalid = 1'b1;
      for (int i = 0; i < 100 && !seen; i++) begin
         #1 seen = arready;
         @(negedge s_axi_aclk);
      end
      arvalid = 1'b0;
      if (!seen) chk("ar_handshake_timeout", 128'(seen), 128'd1);
      seen = 1'b0; data = 'x; resp = 2'bxx; rrid = 'x; last = 1'bx;
      for (int i = 0; i < 100 && !seen; i++) begin
         #1 if (rvalid) begin
            seen = 1'b1; data = rdata; resp = rresp; rrid = rid; last = rlast;
         end
         @(negedge s_axi_aclk);
      end
      if (!seen) chk("r_handshake_timeout", 128'(seen), 128'd1);
   endtask

   initial begin
      logic [1:0]   resp;
      logic [16:0]  rbid;
      logic [127:0] d;
      logic         last;
      int           low, bad, snap_pulses;
      logic [63:0]  snap_size;
      bit           seen;

      s_axi_areset = 1'b1;
      awaddr = '0; awid = '0; awlen = '0; awsize = 3'b100; awvalid = 1'b1;
      wdata = '0; wstrb = '1; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
      araddr = '0; arid = '0; arvalid = 1'b1; rready = 1'b1;
      fifo_full = 1'b0; buf_full = 1'b0; image_change = 1'b0;

      // Reset values, with valids asserted to show readies stay low in reset
      idle(3);
      #1;
      chk("rst_awready", 128'(awready), 128'd0);
      chk("rst_arready", 128'(arready), 128'd0);
      chk("rst_wready",  128'(wready),  128'd0);
      chk("rst_bvalid",  128'(bvalid),  128'd0);
      chk("rst_rvalid",  128'(rvalid),  128'd0);
      chk("rst_irq",     128'(irq_signal), 128'd0);
      chk("rst_size",    {64'd0, image_height, image_width}, 128'd0);
      chk("rst_resp_id", {bresp, rresp, bid, rid}, 128'd0);
      chk("rst_rdata",   rdata, 128'd0);
      chk("rst_pulses",  {fifo_wr_en, buf_wr_en, flush_fifo, data_done}, 128'd0);
      awvalid = 1'b0; arvalid = 1'b0;
      @(negedge s_axi_aclk);
      s_axi_areset = 1'b0;
      idle(2);

      // Image size register and read-back
      wr(a(12'h020), 17'h1ABCD, {64'd0, 32'd100, 32'd100}, resp, rbid);
      chk("size_bresp", 128'(resp), 128'd0);
      chk("size_bid",   128'(rbid), 128'h1ABCD);
      chk("size_regs",  {64'd0, image_height, image_width}, {64'd0, 32'd100, 32'd100});
      rd(a(12'h020), 17'h00055, d, resp, rbid, last);
      chk("size_rdata", d, {64'd0, 32'd100, 32'd100});
      chk("size_rresp", 128'(resp), 128'd0);
      chk("size_rid",   128'(rbid), 128'h00055);
      chk("size_rlast", 128'(last), 128'd1);
      wr(a(12'h020), 17'h00002, {64'hFFFF_FFFF_FFFF_FFFF, 32'd200, 32'd640}, resp, rbid);
      chk("size2_regs", {64'd0, image_height, image_width}, {64'd0, 32'd200, 32'd640});
      rd(a(12'h020), 17'h1FFFF, d, resp, rbid, last);
      chk("size2_rdata", d, {64'd0, 32'd200, 32'd640});

      // Command pulses and FIFO write, with one FIFO-full stall
      wr(a(12'h010), 17'h3, 128'd0, resp, rbid);
      chk("flush_bresp", 128'(resp), 128'd0);
      wr(a(12'h030), 17'h4, 128'd0, resp, rbid);
      wr(a(12'h000), 17'h5, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C, resp, rbid);
      idle(2);
      chk("flush_pulses", 128'(cnt_flush), 128'd1);
      chk("done_pulses",  128'(cnt_done),  128'd1);
      chk("fifo_pulses",  128'(cnt_fifo),  128'd1);
      chk("fifo_din",     last_fifo_din, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C);
      stall_wr(a(12'h000), 128'h55, 1'b0, 4, low, resp);
      idle(2);
      chk("fifo_full_stall", 128'(low), 128'd4);
      chk("fifo_after_stall", 128'(cnt_fifo), 128'd2);
      chk("fifo_din2", last_fifo_din, 128'h55);

      // 625 back-to-back buffer writes
      buf_exp = 0; cnt_buf = 0; bad = 0;
      for (int i = 0; i < 625; i++) begin
         wr(a(12'h040), 17'(i), 128'(i), resp, rbid);
         if (resp !== 2'b00 || rbid !== 17'(i)) bad++;
      end
      idle(2);
      chk("buf_count", 128'(cnt_buf), 128'd625);
      chk("buf_resp_bad", 128'(bad), 128'd0);

      // Same stream with buf_full held for 20 cycles during write 300
      buf_exp = 0; cnt_buf = 0; bad = 0; low = 0;
      for (int i = 0; i < 625; i++) begin
         if (i == 300) begin
            stall_wr(a(12'h040), 128'(i), 1'b1, 20, low, resp);
            if (resp !== 2'b00) bad++;
         end else begin
            wr(a(12'h040), 17'(i), 128'(i), resp, rbid);
            if (resp !== 2'b00) bad++;
         end
      end
      idle(2);
      chk("buf_full_stall", 128'(low), 128'd20);
      chk("buf_count_stall", 128'(cnt_buf), 128'd625);
      chk("buf_resp_bad_stall", 128'(bad), 128'd0);

      // IRQ set by image_change, cleared by 0x60, set by 0x50
      #1 chk("irq_before", 128'(irq_signal), 128'd0);
      @(negedge s_axi_aclk);
      image_change = 1'b1;
      @(negedge s_axi_aclk);
      image_change = 1'b0;
      chk("irq_on_change", 128'(irq_signal), 128'd1);
      rd(a(12'h060), 17'h9, d, resp, rbid, last);
      chk("irq_read_1", d, 128'd1);
      chk("irq_read_resp", 128'(resp), 128'd0);
      wr(a(12'h060), 17'hA, 128'd0, resp, rbid);
      chk("irq_clear", 128'(irq_signal), 128'd0);
      rd(a(12'h060), 17'hB, d, resp, rbid, last);
      chk("irq_read_0", d, 128'd0);
      wr(a(12'h050), 17'hC, 128'd0, resp, rbid);
      chk("irq_set_write", 128'(irq_signal), 128'd1);
      chk("irq_set_bresp", 128'(resp), 128'd0);
      wr(a(12'h060), 17'hD, 128'd0, resp, rbid);
      chk("irq_clear2", 128'(irq_signal), 128'd0);

      // Clear write and image_change in the same cycle: set wins
      aw_phase(a(12'h060), 17'hE, 8'd0);
      wdata = '0; wlast = 1'b1; wvalid = 1'b1; image_change = 1'b1;
      #1 seen = wready;
      chk("same_cycle_wready", 128'(seen), 128'd1);
      @(negedge s_axi_aclk);
      wvalid = 1'b0; wlast = 1'b0; image_change = 1'b0;
      chk("irq_set_wins", 128'(irq_signal), 128'd1);
      b_phase(resp, rbid);
      idle(2);
      chk("irq_set_wins_hold", 128'(irq_signal), 128'd1);

      // Error responses leave every output untouched
      snap_pulses = cnt_fifo + cnt_buf + cnt_flush + cnt_done;
      snap_size = {image_height, image_width};
      wr(a(12'h070), 17'h11, 128'hFFFF_FFFF, resp, rbid);
      chk("bad_ofs_bresp", 128'(resp), 128'd2);
      chk("bad_ofs_bid",   128'(rbid), 128'h11);
      wr(39'h00_A002_0020, 17'h12, 128'd7, resp, rbid);
      chk("bad_base_bresp", 128'(resp), 128'd2);
      aw_phase(a(12'h020), 17'h13, 8'd1);
      w_phase(128'd9, 1'b0);
      w_phase(128'd9, 1'b1);
      b_phase(resp, rbid);
      chk("burst_bresp", 128'(resp), 128'd2);
      idle(2);
      chk("err_no_pulses", 128'(cnt_fifo + cnt_buf + cnt_flush + cnt_done), 128'(snap_pulses));
      chk("err_size_kept", 128'({image_height, image_width}), 128'(snap_size));
      chk("err_irq_kept", 128'(irq_signal), 128'd1);
      rd(a(12'h040), 17'h14, d, resp, rbid, last);
      chk("bad_read_rresp", 128'(resp), 128'd2);
      chk("bad_read_rdata", d, 128'd0);

      // Reset while a response is pending: it is dropped
      bready = 1'b0;
      aw_phase(a(12'h020), 17'h15, 8'd0);
      w_phase({64'd0, 32'd5, 32'd6}, 1'b1);
      idle(2);
      #1 chk("resp_held", 128'(bvalid), 128'd1);
      @(negedge s_axi_aclk);
      s_axi_areset = 1'b1;
      @(negedge s_axi_aclk);
      chk("rst_mid_bvalid", 128'(bvalid), 128'd0);
      chk("rst_mid_irq", 128'(irq_signal), 128'd0);
      chk("rst_mid_size", 128'({image_height, image_width}), 128'd0);
      s_axi_areset = 1'b0;
      bready = 1'b1;
      idle(3);
      #1 chk("no_resp_after_rst", 128'(bvalid), 128'd0);
      @(negedge s_axi_aclk);
      wr(a(12'h020), 17'h16, {64'd0, 32'd3, 32'd4}, resp, rbid);
      chk("post_rst_bresp", 128'(resp), 128'd0);
      chk("post_rst_size", {64'd0, image_height, image_width}, {64'd0, 32'd3, 32'd4});

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
